// File: rtl/lsq_buffer_param.sv
// lsq_buffer_param: in-order load/store queue between dispatch, the ROB and
// the memory controller. Entries allocate at the tail in program order, snoop
// the CDB channels and the local load broadcast for missing operands, and
// execute strictly one at a time from the head.
//
// Ports
//   clk_in, rst_in (async, active-low), rdy_in (0 = freeze)
//   roll_back                  flush speculative entries
//   iss_*                      allocation of one load/store per cycle
//   cdb_valid/tag/value        NUM_CDB packed result channels, channel 0 in LSBs
//   commit_valid/commit_tag    ROB store commit
//   full_out/empty_out/count_out  occupancy
//   mem_req/we/addr/wdata/size, mem_done/mem_rdata  memory handshake
//   ld_bc_valid/tag/value      extended load result broadcast
//   st_rdy_valid/tag           store at head has both operands
module lsq_buffer_param #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned TAG_W      = 5,
    parameter int unsigned NUM_CDB    = 2,
    parameter int unsigned XLEN       = 32
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       roll_back,
    input  logic                       iss_valid,
    input  logic                       iss_is_store,
    input  logic [2:0]                 iss_funct3,
    input  logic [TAG_W-1:0]           iss_tag,
    input  logic [XLEN-1:0]            iss_vj,
    input  logic [TAG_W-1:0]           iss_qj,
    input  logic [XLEN-1:0]            iss_vk,
    input  logic [TAG_W-1:0]           iss_qk,
    input  logic [XLEN-1:0]            iss_imm,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]    cdb_value,
    input  logic                       commit_valid,
    input  logic [TAG_W-1:0]           commit_tag,
    output logic                       full_out,
    output logic                       empty_out,
    output logic [DEPTH_LOG2:0]        count_out,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [XLEN-1:0]            mem_addr,
    output logic [XLEN-1:0]            mem_wdata,
    output logic [1:0]                 mem_size,
    input  logic                       mem_done,
    input  logic [XLEN-1:0]            mem_rdata,
    output logic                       ld_bc_valid,
    output logic [TAG_W-1:0]           ld_bc_tag,
    output logic [XLEN-1:0]            ld_bc_value,
    output logic                       st_rdy_valid,
    output logic [TAG_W-1:0]           st_rdy_tag
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        S_EMPTY, S_WAIT, S_READY, S_SRDY, S_COMMIT, S_MEM, S_SQUASH
    } ent_state_t;

    typedef struct packed {
        logic             is_store;
        logic [2:0]       funct3;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  vj;
        logic [TAG_W-1:0] qj;
        logic [XLEN-1:0]  vk;
        logic [TAG_W-1:0] qk;
        logic [XLEN-1:0]  imm;
    } entry_t;

    ent_state_t st_q [DEPTH];
    ent_state_t st_n [DEPTH];
    entry_t     ent_q [DEPTH];
    entry_t     ent_n [DEPTH];

    logic [DEPTH_LOG2-1:0] head_q, head_n, tail_q, tail_n;
    logic [DEPTH_LOG2:0]   count_q, count_n;

    logic             mem_req_q, mem_req_n, mem_we_q, mem_we_n;
    logic [XLEN-1:0]  mem_addr_q, mem_addr_n, mem_wdata_q, mem_wdata_n;
    logic [1:0]       mem_size_q, mem_size_n;
    logic             ld_bc_valid_q, ld_bc_valid_n;
    logic [TAG_W-1:0] ld_bc_tag_q, ld_bc_tag_n;
    logic [XLEN-1:0]  ld_bc_value_q, ld_bc_value_n;
    logic             st_rdy_valid_q, st_rdy_valid_n;
    logic [TAG_W-1:0] st_rdy_tag_q, st_rdy_tag_n;

    // mem_done arriving while frozen is parked here until rdy_in returns
    logic             done_pend_q;
    logic [XLEN-1:0]  done_rdata_q;
    logic             done_eff;
    logic [XLEN-1:0]  rdata_eff;

    assign done_eff  = mem_done | done_pend_q;
    assign rdata_eff = done_pend_q ? done_rdata_q : mem_rdata;

    // Tag 0 means "value present" and never matches a broadcast
    function automatic logic snoop(input logic [TAG_W-1:0] q, output logic [XLEN-1:0] v);
        snoop = 1'b0;
        v     = '0;
        if (q != '0) begin
            for (int unsigned c = 0; c < NUM_CDB; c++) begin
                if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == q) begin
                    snoop = 1'b1;
                    v     = cdb_value[c*XLEN +: XLEN];
                end
            end
            if (ld_bc_valid_q && ld_bc_tag_q == q) begin
                snoop = 1'b1;
                v     = ld_bc_value_q;
            end
        end
    endfunction

    function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] r);
        case (f3)
            3'b000:  extend = {{(XLEN-8){r[7]}}, r[7:0]};
            3'b001:  extend = {{(XLEN-16){r[15]}}, r[15:0]};
            3'b100:  extend = {{(XLEN-8){1'b0}}, r[7:0]};
            3'b101:  extend = {{(XLEN-16){1'b0}}, r[15:0]};
            default: extend = r;
        endcase
    endfunction

    always_comb begin
        logic [XLEN-1:0]     val;
        logic                hit;
        logic                alloc;
        logic                deq;
        logic [DEPTH_LOG2:0] n;

        val = '0;
        hit = 1'b0;
        deq = 1'b0;
        n   = '0;

        st_n           = st_q;
        ent_n          = ent_q;
        head_n         = head_q;
        tail_n         = tail_q;
        count_n        = count_q;
        mem_req_n      = mem_req_q;
        mem_we_n       = mem_we_q;
        mem_addr_n     = mem_addr_q;
        mem_wdata_n    = mem_wdata_q;
        mem_size_n     = mem_size_q;
        ld_bc_valid_n  = 1'b0;
        ld_bc_tag_n    = ld_bc_tag_q;
        ld_bc_value_n  = ld_bc_value_q;
        st_rdy_valid_n = 1'b0;
        st_rdy_tag_n   = st_rdy_tag_q;

        // Wakeup; readiness uses the post-capture tags
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (st_q[i] == S_WAIT) begin
                hit = snoop(ent_q[i].qj, val);
                if (hit) begin
                    ent_n[i].vj = val;
                    ent_n[i].qj = '0;
                end
                hit = snoop(ent_q[i].qk, val);
                if (hit) begin
                    ent_n[i].vk = val;
                    ent_n[i].qk = '0;
                end
                if (ent_n[i].qj == '0 && (ent_n[i].qk == '0 || !ent_q[i].is_store))
                    st_n[i] = S_READY;
            end
        end

        // Head execution
        case (st_q[head_q])
            S_READY: begin
                if (ent_q[head_q].is_store) begin
                    st_n[head_q]   = S_SRDY;
                    st_rdy_valid_n = 1'b1;
                    st_rdy_tag_n   = ent_q[head_q].tag;
                end else begin
                    st_n[head_q] = S_MEM;
                end
            end
            S_SRDY: begin
                if (commit_valid && commit_tag == ent_q[head_q].tag)
                    st_n[head_q] = S_COMMIT;
            end
            S_COMMIT: st_n[head_q] = S_MEM;
            S_MEM, S_SQUASH: begin
                if (!mem_req_q) begin
                    mem_req_n   = 1'b1;
                    mem_we_n    = ent_q[head_q].is_store;
                    mem_addr_n  = ent_q[head_q].vj + ent_q[head_q].imm;
                    mem_wdata_n = ent_q[head_q].vk;
                    mem_size_n  = ent_q[head_q].funct3[1:0];
                end else if (done_eff) begin
                    deq          = 1'b1;
                    mem_req_n    = 1'b0;
                    st_n[head_q] = S_EMPTY;
                    head_n       = head_q + 1'b1;
                    if (st_q[head_q] == S_MEM && !ent_q[head_q].is_store && !roll_back) begin
                        ld_bc_valid_n = 1'b1;
                        ld_bc_tag_n   = ent_q[head_q].tag;
                        ld_bc_value_n = extend(ent_q[head_q].funct3, rdata_eff);
                    end
                end
            end
            default: ;
        endcase

        // Allocation at tail; full is judged on the registered count only
        alloc = iss_valid && (count_q != FULL_CNT) && !roll_back;
        if (alloc) begin
            ent_n[tail_q].is_store = iss_is_store;
            ent_n[tail_q].funct3   = iss_funct3;
            ent_n[tail_q].tag      = iss_tag;
            ent_n[tail_q].vj       = iss_vj;
            ent_n[tail_q].qj       = iss_qj;
            ent_n[tail_q].vk       = iss_vk;
            ent_n[tail_q].qk       = iss_qk;
            ent_n[tail_q].imm      = iss_imm;
            hit = snoop(iss_qj, val);
            if (hit) begin
                ent_n[tail_q].vj = val;
                ent_n[tail_q].qj = '0;
            end
            hit = snoop(iss_qk, val);
            if (hit) begin
                ent_n[tail_q].vk = val;
                ent_n[tail_q].qk = '0;
            end
            st_n[tail_q] = S_WAIT;
            tail_n       = tail_q + 1'b1;
        end

        case ({alloc, deq})
            2'b10:   count_n = count_q + 1'b1;
            2'b01:   count_n = count_q - 1'b1;
            default: count_n = count_q;
        endcase

        // Rollback: committed stores (waiting or in flight) survive, a head
        // load already in MEM finishes silently; everything else is dropped.
        // Survivors are always contiguous from head since only head executes.
        if (roll_back) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                case (st_q[i])
                    S_COMMIT, S_SQUASH: n = n + 1'b1;
                    S_MEM: begin
                        n = n + 1'b1;
                        if (!ent_q[i].is_store && st_n[i] == S_MEM)
                            st_n[i] = S_SQUASH;
                    end
                    default: st_n[i] = S_EMPTY;
                endcase
            end
            st_rdy_valid_n = 1'b0;
            tail_n         = head_q + n[DEPTH_LOG2-1:0];
            count_n        = n - {{DEPTH_LOG2{1'b0}}, deq};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                st_q[i]  <= S_EMPTY;
                ent_q[i] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_size_q     <= '0;
            ld_bc_valid_q  <= 1'b0;
            ld_bc_tag_q    <= '0;
            ld_bc_value_q  <= '0;
            st_rdy_valid_q <= 1'b0;
            st_rdy_tag_q   <= '0;
            done_pend_q    <= 1'b0;
            done_rdata_q   <= '0;
        end else if (rdy_in) begin
            st_q           <= st_n;
            ent_q          <= ent_n;
            head_q         <= head_n;
            tail_q         <= tail_n;
            count_q        <= count_n;
            mem_req_q      <= mem_req_n;
            mem_we_q       <= mem_we_n;
            mem_addr_q     <= mem_addr_n;
            mem_wdata_q    <= mem_wdata_n;
            mem_size_q     <= mem_size_n;
            ld_bc_valid_q  <= ld_bc_valid_n;
            ld_bc_tag_q    <= ld_bc_tag_n;
            ld_bc_value_q  <= ld_bc_value_n;
            st_rdy_valid_q <= st_rdy_valid_n;
            st_rdy_tag_q   <= st_rdy_tag_n;
            done_pend_q    <= 1'b0;
        end else if (mem_done) begin
            done_pend_q  <= 1'b1;
            done_rdata_q <= mem_rdata;
        end
    end

    assign full_out     = (count_q == FULL_CNT);
    assign empty_out    = (count_q == '0);
    assign count_out    = count_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_size     = mem_size_q;
    assign ld_bc_valid  = ld_bc_valid_q;
    assign ld_bc_tag    = ld_bc_tag_q;
    assign ld_bc_value  = ld_bc_value_q;
    assign st_rdy_valid = st_rdy_valid_q;
    assign st_rdy_tag   = st_rdy_tag_q;

endmodule
